// File: rtl/writeback_phase.sv
// Writeback stage: retires execute results to the GPR file and completes loads
// by extracting the addressed bytes from the returned memory word.
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef OPCODE_W
`define OPCODE_W 6
`endif
`ifndef MICRO_NOP
`define MICRO_NOP 'h00
`define MICRO_ADD 'h01
`define MICRO_SUB 'h02
`define MICRO_AND 'h03
`define MICRO_OR  'h04
`define MICRO_XOR 'h05
`define MICRO_SHL 'h06
`define MICRO_LB  'h10
`define MICRO_LD  'h11
`define MICRO_LQ  'h12
`define MICRO_SB  'h18
`define MICRO_SD  'h19
`define MICRO_SQ  'h1A
`define MICRO_JMP 'h20
`define MICRO_JZ  'h21
`define MICRO_JNZ 'h22
`define MICRO_JLT 'h23
`endif

module writeback_phase #(
  parameter int unsigned REG_W      = 64,
  parameter int unsigned REG_ADDR_W = `REG_ADDR_W,
  parameter int unsigned OPCODE_W   = `OPCODE_W,
  parameter int unsigned DATA_W     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ew_valid,
  input  logic [OPCODE_W-1:0]   ew_opcode,
  input  logic [REG_ADDR_W-1:0] ew_reg_addr_d,
  input  logic [REG_W-1:0]      ew_d,
  input  logic [2:0]            ew_ld_offset,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  wb_stall,
  output logic                  gpr_we,
  output logic [REG_ADDR_W-1:0] gpr_waddr,
  output logic [REG_W-1:0]      gpr_wdata,
  output logic [63:0]           instret,
  output logic                  err_misalign,
  output logic                  err_spurious
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state;
  logic [OPCODE_W-1:0]   lat_opcode;
  logic [REG_ADDR_W-1:0] lat_addr;
  logic [2:0]            lat_offset;
  logic [DATA_W-1:0]     shifted;
  logic [REG_W-1:0]      ld_data;
  logic                  ld_misalign;

  function automatic logic is_load(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_W'(`MICRO_LB)) || (op == OPCODE_W'(`MICRO_LD)) ||
           (op == OPCODE_W'(`MICRO_LQ));
  endfunction

  function automatic logic is_nowrite(input logic [OPCODE_W-1:0] op);
    return (op == OPCODE_W'(`MICRO_SB))  || (op == OPCODE_W'(`MICRO_SD))  ||
           (op == OPCODE_W'(`MICRO_SQ))  || (op == OPCODE_W'(`MICRO_NOP)) ||
           (op == OPCODE_W'(`MICRO_JMP)) || (op == OPCODE_W'(`MICRO_JZ))  ||
           (op == OPCODE_W'(`MICRO_JNZ)) || (op == OPCODE_W'(`MICRO_JLT));
  endfunction

  // Upstream must hold a load while it is presented in IDLE and throughout WAIT.
  assign wb_stall = !rst && ((state == IDLE && ew_valid && is_load(ew_opcode)) ||
                             (state == WAIT));

  // Byte extraction; bytes shifted in past the top of the word read as zero.
  assign shifted = mem_rdata >> {lat_offset, 3'b000};

  always_comb begin
    ld_data     = REG_W'(mem_rdata);
    ld_misalign = 1'b0;
    if (lat_opcode == OPCODE_W'(`MICRO_LB)) begin
      ld_data = REG_W'(shifted[7:0]);
    end else if (lat_opcode == OPCODE_W'(`MICRO_LD)) begin
      ld_data     = REG_W'(shifted[31:0]);
      ld_misalign = (lat_offset > 3'd4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lat_opcode   <= '0;
      lat_addr     <= '0;
      lat_offset   <= '0;
      gpr_we       <= 1'b0;
      gpr_waddr    <= '0;
      gpr_wdata    <= '0;
      instret      <= '0;
      err_misalign <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      gpr_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_rvalid) begin
            err_spurious <= 1'b1;
          end
          if (ew_valid) begin
            if (is_load(ew_opcode)) begin
              state      <= WAIT;
              lat_opcode <= ew_opcode;
              lat_addr   <= ew_reg_addr_d;
              lat_offset <= ew_ld_offset;
            end else begin
              instret <= instret + 64'd1;
              if (!is_nowrite(ew_opcode)) begin
                gpr_we    <= 1'b1;
                gpr_waddr <= ew_reg_addr_d;
                gpr_wdata <= ew_d;
              end
            end
          end
        end
        WAIT: begin
          // A new instruction presented alongside rvalid waits for the next IDLE cycle.
          if (mem_rvalid) begin
            state     <= IDLE;
            gpr_we    <= 1'b1;
            gpr_waddr <= lat_addr;
            gpr_wdata <= ld_data;
            instret   <= instret + 64'd1;
            if (ld_misalign) begin
              err_misalign <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/writeback_phase.md
WRITEBACK_PHASE -- requirements
Module: writeback_phase

Interface
REQ-001 Parameter REG_W, default 64, GPR and data-path width.
REQ-002 Parameter REG_ADDR_W, default `REG_ADDR_W, GPR address width.
REQ-003 Parameter OPCODE_W, default `OPCODE_W, micro-op opcode width.
REQ-004 Parameter DATA_W, default 64, memory read-data width (DATA_W == REG_W).
REQ-005 Port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 Port ew_valid, input, 1 bit: execute-to-writeback instruction present.
REQ-008 Port ew_opcode, input, OPCODE_W bits: micro-op of the presented instruction.
REQ-009 Port ew_reg_addr_d, input, REG_ADDR_W bits: destination GPR.
REQ-010 Port ew_d, input, REG_W bits: ALU result.
REQ-011 Port ew_ld_offset, input, 3 bits: byte offset within the 64-bit memory word.
REQ-012 Port mem_rdata, input, DATA_W bits: memory read word.
REQ-013 Port mem_rvalid, input, 1 bit: mem_rdata valid this cycle.
REQ-014 Port wb_stall, output, 1 bit: upstream holds all ew_* stable while high.
REQ-015 Port gpr_we, output, 1 bit: GPR write strobe.
REQ-016 Port gpr_waddr, output, REG_ADDR_W bits: GPR write address.
REQ-017 Port gpr_wdata, output, REG_W bits: GPR write data.
REQ-018 Port instret, output, 64 bits: retired-instruction counter.
REQ-019 Port err_misalign, output, 1 bit: sticky misaligned-load flag.
REQ-020 Port err_spurious, output, 1 bit: sticky unexpected-rvalid flag.

Function
REQ-021 Opcode classes are fixed as follows.
- Load: MICRO_LB, MICRO_LD, MICRO_LQ.
- No-write: MICRO_SB/SD/SQ, all MICRO_J* branches, MICRO_NOP.
- Write: every other opcode.
REQ-022 FSM states are IDLE and WAIT; the state resets to IDLE.
REQ-023 An instruction is accepted in IDLE when ew_valid=1.
REQ-024 On acceptance of a load, the FSM goes IDLE->WAIT and the block latches the opcode, reg_addr_d and ld_offset.
REQ-025 WAIT->IDLE occurs on the cycle mem_rvalid=1; the FSM stays in WAIT otherwise, with no timeout.
REQ-026 wb_stall is combinational: (IDLE & ew_valid & load) | WAIT.
REQ-027 No instruction is accepted while in WAIT, including the cycle mem_rvalid arrives.
REQ-028 A write-class instruction accepted at edge N produces gpr_we=1, gpr_waddr=ew_reg_addr_d and gpr_wdata=ew_d at edge N+1; latency is 1 cycle.
REQ-029 A no-write instruction produces gpr_we=0 and retires at edge N+1.
REQ-030 A load produces gpr_we=1 with the extracted data registered at the edge after the mem_rvalid cycle.
REQ-031 Load extraction uses off = latched ld_offset.
- LB: zero-extend mem_rdata[8*off+:8].
- LD: zero-extend bytes off..off+3 (x86 32-bit semantics).
- LQ: full mem_rdata; offset is ignored.
REQ-032 For LD with off>4, bytes beyond byte 7 read as zero, the write still occurs, and err_misalign is set.
REQ-033 gpr_we is a single-cycle pulse per instruction and is never asserted two consecutive cycles for one instruction.
REQ-034 instret increments by 1 on each cycle gpr_we would be pulsed or a no-write instruction retires; it wraps modulo 2^64.
REQ-035 mem_rvalid in IDLE is ignored for data and sets err_spurious.
REQ-036 The err_* flags are cleared only by reset.
REQ-037 Simultaneous mem_rvalid and ew_valid in WAIT: the load completes, and the new instruction is accepted in the following IDLE cycle.

Reset
REQ-038 rst=1 asynchronously forces the following to 0 and the FSM to IDLE: wb_stall-state, gpr_we, gpr_waddr, gpr_wdata, instret, err_misalign, err_spurious, and all latched fields.
REQ-039 Reset asserted in WAIT abandons the outstanding load with no GPR write; a later stale mem_rvalid sets err_spurious.
REQ-040 While rst=1, gpr_we=0 and wb_stall=0 regardless of inputs.

Verification
REQ-041 ADD: ew_valid=1, reg=3, ew_d=0x1234 -> next edge gpr_we=1, waddr=3, wdata=0x1234; instret=1.
REQ-042 LB with offset=5, mem_rvalid 3 cycles later with rdata=0x0011_2233_4455_6677 -> wb_stall high 4 cycles, then gpr_wdata=0x22 once.
REQ-043 LD with offset=6, rdata=0xAABB_CCDD_0000_0000 -> gpr_wdata=0x0000_AABB and err_misalign=1.
REQ-044 Back-to-back LQ then SUB with rvalid coinciding with the held SUB -> LQ data written first, SUB written exactly one cycle later, instret=2.
REQ-045 Reset pulse during WAIT then mem_rvalid=1 -> no gpr_we, err_spurious=1, instret=0.
REQ-046 Preload instret=2^64-1 via 2^64-1 retirements (forced), then one more retirement -> instret=0.
